// File: rtl/phsh_pkg.sv
// Shared constants, FSM state type and frame builder for the phase-shifter serial transmitter.
// Build option: define PHSH_PARITY_EN to append an even-parity bit after each phase word.
package phsh_pkg;

  localparam int WORD_W     = 5;
  localparam int NUM_ELEM   = 5;
  localparam int BITS_BASE  = WORD_W * NUM_ELEM;        // 25
  localparam int BITS_PAR   = (WORD_W + 1) * NUM_ELEM;  // 30
  localparam int BIT_CNT_W  = $clog2(BITS_PAR);         // 5
  localparam int HALF_CNT_W = 8;

`ifdef PHSH_PARITY_EN
  localparam int FRAME_BITS = BITS_PAR;
`else
  localparam int FRAME_BITS = BITS_BASE;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Element e+1 lives in ph[e]; element 1 is nearest the transmitter.
  typedef logic [NUM_ELEM-1:0][WORD_W-1:0] ph_vec_t;

  // Lay out the frame so the MSB is the first bit on the wire:
  // element 5 occupies the top bits, element 1 the bottom.
  function automatic logic [FRAME_BITS-1:0] build_frame(input ph_vec_t ph);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    for (int e = 0; e < NUM_ELEM; e++) begin
`ifdef PHSH_PARITY_EN
      f[e*(WORD_W+1) +: (WORD_W+1)] = {ph[e], ^ph[e]};
`else
      f[e*WORD_W +: WORD_W] = ph[e];
`endif
    end
    return f;
  endfunction

endpackage

// File: rtl/phsh_clk_div.sv
// sclk half-period tick generator: one-cycle tick every CLK_DIV enabled cycles.
// Counter restarts from zero whenever enable drops so each frame starts phase-aligned.
module phsh_clk_div
  import phsh_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam logic [HALF_CNT_W-1:0] CNT_MAX = HALF_CNT_W'(CLK_DIV - 1);

  logic [HALF_CNT_W-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == CNT_MAX);

  // Count within the half-period; reload explicitly on tick or when disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable)   cnt_d = '0;
    else if (tick) cnt_d = '0;
    else           cnt_d = cnt_q + 1'b1;
  end

  // Half-period counter register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/phsh_serial_tx.sv
// Serial loader for a daisy-chained phase-shifter array: captures five phase words on load,
// shifts them out MSB first (element 5 first) on sclk/sdata, then pulses le to latch.
// Build option: PHSH_PARITY_EN appends an even-parity bit after each word (30-bit frame).
module phsh_serial_tx
  import phsh_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int LE_HALFS = 2
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] ph1,
  input  logic [WORD_W-1:0] ph2,
  input  logic [WORD_W-1:0] ph3,
  input  logic [WORD_W-1:0] ph4,
  input  logic [WORD_W-1:0] ph5,
  output logic              sclk,
  output logic              sdata,
  output logic              le,
  output logic              busy,
  output logic              done
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LE_LAST  = BIT_CNT_W'(LE_HALFS - 1);

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                    sclk_q, sclk_d;
  logic                    sdata_q, sdata_d;
  logic                    le_q, le_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    tick;
  logic                    load_ok;
  logic                    last_bit;
  logic                    le_end;
  logic [FRAME_BITS-1:0]   frame_new;

  assign frame_new = build_frame({ph5, ph4, ph3, ph2, ph1});
  // A load is only honoured when fully idle; the done cycle counts as not ready.
  assign load_ok   = load && (state_q == ST_IDLE) && !done_q;
  // bit_cnt doubles as the le half-period counter while latching.
  assign last_bit  = (bit_cnt_q == LAST_BIT);
  assign le_end    = (bit_cnt_q == LE_LAST);

  phsh_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .enable  (state_q != ST_IDLE),
    .tick    (tick)
  );

  // FSM state register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: a frame ends on the falling sclk edge of the last bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load_ok)                     state_d = ST_SHIFT;
      ST_SHIFT: if (tick && sclk_q && last_bit)  state_d = ST_LATCH;
      ST_LATCH: if (tick && le_end)              state_d = ST_IDLE;
      default:                                   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath: sdata moves only on the falling sclk edge.
  always_comb begin
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    sdata_d   = sdata_q;
    le_d      = le_q;
    done_d    = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        sclk_d    = 1'b0;
        sdata_d   = 1'b0;
        le_d      = 1'b0;
        bit_cnt_d = '0;
        if (load_ok) begin
          sdata_d = frame_new[FRAME_BITS-1];
          frame_d = frame_new << 1;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (last_bit) begin
            sclk_d    = 1'b0;
            sdata_d   = 1'b0;
            le_d      = 1'b1;
            bit_cnt_d = '0;
            frame_d   = '0;
          end else begin
            sclk_d    = 1'b0;
            sdata_d   = frame_q[FRAME_BITS-1];
            frame_d   = frame_q << 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_LATCH: begin
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        if (tick) begin
          if (le_end) begin
            le_d      = 1'b0;
            done_d    = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        sclk_d    = 1'b0;
        sdata_d   = 1'b0;
        le_d      = 1'b0;
        bit_cnt_d = '0;
        frame_d   = '0;
      end
    endcase
  end

  // Datapath and output registers; reset aborts any frame without an le pulse.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q   <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      le_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      le_q      <= le_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sclk  = sclk_q;
  assign sdata = sdata_q;
  assign le    = le_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_phsh_serial_tx.sv
// Scoreboard bench: two transmitters (CLK_DIV=2/LE_HALFS=2 and CLK_DIV=1/LE_HALFS=3).
// Stimulus pushes the expected bit sequence per frame; a negedge monitor rebuilds what
// appeared on the wire and compares when done pulses.
module tb_phsh_serial_tx;
  import phsh_pkg::*;

  logic sys_clk = 1'b0;
  logic rst_n;
  logic       load_s  [2];
  logic [4:0] ph_s    [2][5];
  logic       sclk_s  [2];
  logic       sdata_s [2];
  logic       le_s    [2];
  logic       busy_s  [2];
  logic       done_s  [2];

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    phsh_serial_tx #(
      .CLK_DIV  (g == 0 ? 2 : 1),
      .LE_HALFS (g == 0 ? 2 : 3)
    ) u_dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .load    (load_s[g]),
      .ph1     (ph_s[g][0]),
      .ph2     (ph_s[g][1]),
      .ph3     (ph_s[g][2]),
      .ph4     (ph_s[g][3]),
      .ph5     (ph_s[g][4]),
      .sclk    (sclk_s[g]),
      .sdata   (sdata_s[g]),
      .le      (le_s[g]),
      .busy    (busy_s[g]),
      .done    (done_s[g])
    );
  end

  function automatic int cdiv(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  function automatic int leh(input int g);
    return (g == 0) ? 2 : 3;
  endfunction

`ifdef PHSH_PARITY_EN
  localparam int NB = 30;
`else
  localparam int NB = 25;
`endif

  function automatic int busy_len(input int g);
    return (2 * NB + leh(g)) * cdiv(g);
  endfunction

  // Reference: wire order is element 5..1, each word MSB first, optional parity after it.
  function automatic logic [29:0] model_bits(input logic [4:0][4:0] pk);
    logic [29:0] r;
    int k;
    r = '0;
    k = 0;
    for (int e = 4; e >= 0; e--) begin
      for (int b = 4; b >= 0; b--) begin
        r[k] = pk[e][b];
        k++;
      end
`ifdef PHSH_PARITY_EN
      r[k] = ^pk[e];
      k++;
`endif
    end
    return r;
  endfunction

  logic [29:0] q0[$];
  logic [29:0] q1[$];

  function automatic void push_exp(input int g, input logic [29:0] v);
    if (g == 0) q0.push_back(v); else q1.push_back(v);
  endfunction

  function automatic int q_size(input int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [29:0] pop_exp(input int g);
    return (g == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  function automatic void chk(input bit ok, input string name, input int g,
                              input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h t=%0t", name, g, act, req, $time);
    end
  endfunction

  // Monitor state per instance.
  bit          p_sclk [2], p_sdata [2], p_busy [2], p_done [2];
  int          busy_cnt [2], le_cnt [2], nbits [2], hi_run [2], lo_run [2];
  logic [29:0] rx [2];

  always @(negedge sys_clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        p_sclk[g] = 0; p_sdata[g] = 0; p_busy[g] = 0; p_done[g] = 0;
        busy_cnt[g] = 0; le_cnt[g] = 0; nbits[g] = 0; hi_run[g] = 0; lo_run[g] = 0;
        rx[g] = '0;
      end else begin
        if (!busy_s[g])
          chk({sclk_s[g], sdata_s[g], le_s[g]} == 3'b000, "idle_lines", g,
              {sclk_s[g], sdata_s[g], le_s[g]}, 0);
        if (le_s[g]) begin
          chk(!sclk_s[g] && !sdata_s[g], "latch_lines", g, {sclk_s[g], sdata_s[g]}, 0);
          chk(busy_s[g], "latch_busy", g, busy_s[g], 1);
          le_cnt[g]++;
        end
        if (sdata_s[g] != p_sdata[g])
          chk(!sclk_s[g], "sdata_change_sclk_high", g, sclk_s[g], 0);
        if (!p_sclk[g] && sclk_s[g]) begin
          chk(lo_run[g] == cdiv(g), "sclk_low_len", g, lo_run[g], cdiv(g));
          lo_run[g] = 0;
          if (nbits[g] < 30) rx[g][nbits[g]] = sdata_s[g];
          nbits[g]++;
        end
        if (p_sclk[g] && !sclk_s[g]) begin
          chk(hi_run[g] == cdiv(g), "sclk_high_len", g, hi_run[g], cdiv(g));
          hi_run[g] = 0;
        end
        if (busy_s[g]) begin
          busy_cnt[g]++;
          if (sclk_s[g]) hi_run[g]++;
          else if (!le_s[g]) lo_run[g]++;
        end
        if (p_done[g]) chk(!done_s[g], "done_width", g, done_s[g], 0);
        if (done_s[g]) begin
          chk(p_busy[g] && !busy_s[g], "done_after_busy", g, {p_busy[g], busy_s[g]}, 2'b10);
          if (q_size(g) == 0) begin
            chk(0, "unexpected_frame", g, nbits[g], 0);
          end else begin
            logic [29:0] ev;
            ev = pop_exp(g);
            chk(rx[g] == ev, "frame_bits", g, rx[g], ev);
            chk(nbits[g] == NB, "bit_count", g, nbits[g], NB);
            chk(busy_cnt[g] == busy_len(g), "busy_len", g, busy_cnt[g], busy_len(g));
            chk(le_cnt[g] == leh(g) * cdiv(g), "le_len", g, le_cnt[g], leh(g) * cdiv(g));
          end
          busy_cnt[g] = 0; le_cnt[g] = 0; nbits[g] = 0; hi_run[g] = 0; lo_run[g] = 0;
          rx[g] = '0;
        end
        p_sclk[g] = sclk_s[g]; p_sdata[g] = sdata_s[g];
        p_busy[g] = busy_s[g]; p_done[g] = done_s[g];
      end
    end
  end

  // Entered 1ns after a rising edge; load is sampled at the next edge.
  // poke=1: extra load at frame cycle 10; poke=2: extra load while done is high.
  task automatic run_frame(input int g, input logic [4:0][4:0] pk, input int extra,
                           input int poke);
    int b;
    b = busy_len(g);
    for (int e = 0; e < 5; e++) ph_s[g][e] = pk[e];
    load_s[g] = 1'b1;
    push_exp(g, model_bits(pk));
    @(posedge sys_clk); #1;
    load_s[g] = 1'b0;
    for (int i = 1; i <= b + 1 + extra; i++) begin
      @(posedge sys_clk); #1;
      for (int e = 0; e < 5; e++) ph_s[g][e] = 5'($urandom);
      if (poke == 1) load_s[g] = (i == 9);
      if (poke == 2) load_s[g] = (i == b);
    end
    load_s[g] = 1'b0;
  endtask

  // Reset instance 0 while bit 12 is on the wire, then release.
  task automatic reset_mid(input logic [4:0][4:0] pk);
    logic [29:0] dropped;
    for (int e = 0; e < 5; e++) ph_s[0][e] = pk[e];
    load_s[0] = 1'b1;
    push_exp(0, model_bits(pk));
    @(posedge sys_clk); #1;
    load_s[0] = 1'b0;
    repeat (12 * 2 * cdiv(0)) @(posedge sys_clk);
    #2;
    chk(busy_s[0], "busy_before_reset", 0, busy_s[0], 1);
    rst_n = 1'b0;
    #1;
    chk({sclk_s[0], sdata_s[0], le_s[0], busy_s[0], done_s[0]} == 5'b0, "reset_outputs", 0,
        {sclk_s[0], sdata_s[0], le_s[0], busy_s[0], done_s[0]}, 0);
    dropped = pop_exp(0);
    repeat (3) begin
      @(posedge sys_clk); #1;
      chk(!le_s[0], "no_le_in_reset", 0, le_s[0], 0);
    end
    rst_n = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  initial begin
    logic [4:0][4:0] pk;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      load_s[g] = 1'b0;
      for (int e = 0; e < 5; e++) ph_s[g][e] = '0;
    end
    repeat (3) @(posedge sys_clk);
    #1;
    for (int g = 0; g < 2; g++)
      chk({sclk_s[g], sdata_s[g], le_s[g], busy_s[g], done_s[g]} == 5'b0, "reset_state", g,
          {sclk_s[g], sdata_s[g], le_s[g], busy_s[g], done_s[g]}, 0);
    rst_n = 1'b1;
    @(posedge sys_clk); #1;

    run_frame(0, {5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 0, 0);
    run_frame(0, {5'b10110, 5'd0, 5'd0, 5'd0, 5'd0}, 1, 0);
    pk = 25'($urandom);
    run_frame(0, pk, 0, 1);
    pk = 25'($urandom);
    run_frame(0, pk, 0, 2);
    reset_mid({5'd5, 5'd4, 5'd3, 5'd2, 5'd1});
    run_frame(0, {5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 0, 0);
    run_frame(1, {5'h1f, 5'h1f, 5'h1f, 5'h1f, 5'h1f}, 0, 0);
    run_frame(1, {5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 2, 1);
    for (int i = 0; i < 8; i++) begin
      pk = 25'($urandom);
      run_frame(i % 2, pk, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    repeat (10) @(posedge sys_clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk(q_size(g) == 0, "frames_outstanding", g, q_size(g), 0);
      chk(!busy_s[g], "busy_at_end", g, busy_s[g], 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/phsh_serial_tx.md
PHSH_SERIAL_TX -- requirements
Module: phsh_serial_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, sys_clk cycles per sclk half-period (legal 1..255).
REQ-002 SHALL have parameter LE_HALFS, default 2, latch-enable width in sclk half-periods (legal 1..15).
REQ-003 SHALL have port sys_clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port load  input  1  single-cycle request to transmit captured phase words.
REQ-006 SHALL have ports ph1..ph5  input  5 each  element phase codes from the phase lookup outputs.
REQ-007 SHALL have port sclk  output  1  serial clock to phase-shifter chain.
REQ-008 SHALL have port sdata  output  1  serial data, MSB first.
REQ-009 SHALL have port le  output  1  latch enable to phase shifters, active high.
REQ-010 SHALL have ports busy, done  output  1 each  frame in progress; one-cycle completion pulse.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, LATCH; IDLE->SHIFT on load, SHIFT->LATCH after last bit, LATCH->IDLE after le period.
REQ-012 SHALL capture ph1..ph5 into an internal frame register on the sys_clk edge where load=1 in IDLE; later input changes do not affect the frame.
REQ-013 SHALL transmit element 5 first, element 1 last, each word MSB first (daisy chain: element 1 nearest).
REQ-014 SHALL hold each bit on sdata for 2*CLK_DIV cycles: sclk low for first CLK_DIV, high for second CLK_DIV; sdata changes only while sclk low.
REQ-015 SHALL in LATCH hold sclk=0, sdata=0, le=1 for LE_HALFS*CLK_DIV cycles.
REQ-016 SHALL assert busy from the cycle after load is captured until leaving LATCH: N bits gives busy for (2N+LE_HALFS)*CLK_DIV cycles; N=25 base.
REQ-017 SHALL pulse done for exactly one cycle, the first cycle after busy falls, in IDLE.
REQ-018 SHALL ignore load while busy=1 or done=1 (no queueing, no frame corruption).
REQ-019 SHALL accept a new load in the cycle done is low and state is IDLE, giving back-to-back frames with one idle cycle minimum.
REQ-020 SHALL keep sclk=0, sdata=0, le=0 in IDLE.
REQ-021 SHALL use bit counter width ceil(log2(30)) and half-period counter width 8, wrapping only via explicit reload.

Reset
REQ-022 SHALL on rst_n=0 immediately force state IDLE, sclk=0, sdata=0, le=0, busy=0, done=0, counters and frame register 0.
REQ-023 SHALL abort any frame in progress on reset mid-operation, with no le pulse issued; first load after rst_n release starts a clean frame.

Configuration
REQ-024 SHALL, with macro PHSH_PARITY_EN defined, append one even-parity bit after each 5-bit word (N=30, element order unchanged).
REQ-025 SHALL, without PHSH_PARITY_EN, send 25 bits and contain no parity logic.

Structure
REQ-026 SHALL take WORD_W=5, NUM_ELEM=5, state enum and bit-count constants from shared package phsh_pkg.
REQ-027 SHALL place the sclk half-period tick generator in sub-module phsh_clk_div (enable, tick output, CLK_DIV parameter).

Verification
REQ-028 SHALL cover: ph1..ph5=1,2,3,4,5, CLK_DIV=2, load pulse -> sdata sequence 00101 00100 00011 00010 00001, busy 104 cycles, le high 4 cycles, done 1 cycle.
REQ-029 SHALL cover: load asserted again at cycle 10 of a frame -> frame unchanged, no second frame, single done.
REQ-030 SHALL cover: rst_n low at bit 12 -> all outputs 0 same cycle, no le; new load after release -> full correct frame.
REQ-031 SHALL cover: PHSH_PARITY_EN, ph5=5'b10110, others 0 -> first 6 bits 101101, busy 124 cycles at CLK_DIV=2.
REQ-032 SHALL cover: CLK_DIV=1, all ph=5'b11111 -> sclk toggles every cycle, 25 rising edges, sdata=1 at each rising edge.
REQ-033 SHALL cover: ph inputs changed every cycle during frame -> transmitted bits match values captured at load.
